// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: load-size encodings and the
// helper that sizes the byte-offset field of an address.
package mem_wb_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   // Number of low address bits that select a byte within a DW-bit word.
   function automatic int addr_lo_w(input int dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational sub-word load aligner: picks a byte/half/word lane out of a
// memory word and zero- or sign-extends it to the full datapath width.
module load_align
   import mem_wb_pkg::*;
#(
   parameter int DW = 32,
   localparam int LO_W = addr_lo_w(DW)
) (
   input  logic [DW-1:0]   word,
   input  logic [LO_W-1:0] lo,
   input  logic [1:0]      size,
   input  logic            load_unsigned,
   output logic [DW-1:0]   result
);

   localparam logic [LO_W-1:0] HALF_MASK = {LO_W{1'b1}} << 1;
   localparam logic [LO_W-1:0] WORD_MASK = {LO_W{1'b1}} << 2;

   logic [LO_W-1:0] offset;
   logic [DW-1:0]   shifted;

   // Low offset bits below the access size are dropped, so misaligned
   // halfword/word loads simply read the naturally aligned container.
   always_comb begin
      offset  = lo;
      shifted = '0;
      result  = '0;
      case (size)
         LS_BYTE: offset = lo;
         LS_HALF: offset = lo & HALF_MASK;
         default: offset = lo & WORD_MASK;
      endcase
      shifted = word >> {offset, 3'b000};
      case (size)
         LS_BYTE: begin
            if (load_unsigned) result = DW'(shifted[7:0]);
            else               result = DW'($signed(shifted[7:0]));
         end
         LS_HALF: begin
            if (load_unsigned) result = DW'(shifted[15:0]);
            else               result = DW'($signed(shifted[15:0]));
         end
         default: begin
            if (load_unsigned) result = DW'(shifted[31:0]);
            else               result = DW'($signed(shifted[31:0]));
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: holds the write-back payload with stall/flush
// control, drives the register-file write port and forwarding path, and
// counts retired instructions.
module mem_wb_pipe_reg
   import mem_wb_pkg::*;
#(
   parameter int DW       = 32,
   parameter int RA_W     = 5,
   parameter int CNT_W    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic                       mem_to_reg_in,
   input  logic                       reg_write_in,
   input  logic [RA_W-1:0]            rd_in,
   input  logic [DW-1:0]              alu_result_in,
   input  logic [DW-1:0]              mem_data_in,
   input  logic [1:0]                 load_size_in,
   input  logic                       load_unsigned_in,
   output logic                       wb_valid,
   output logic                       wb_reg_write,
   output logic [RA_W-1:0]            wb_rd,
   output logic [DW-1:0]              wb_data,
   output logic                       fwd_valid,
   output logic [RA_W-1:0]            fwd_rd,
   output logic [DW-1:0]              fwd_data,
   output logic [CNT_W-1:0]           retired_count
);

   localparam int ADDR_LO_W = addr_lo_w(DW);

   logic             valid_q;
   logic             mem_to_reg_q;
   logic             reg_write_q;
   logic [RA_W-1:0]  rd_q;
   logic [DW-1:0]    alu_q;
   logic [DW-1:0]    mem_data_q;
   logic [1:0]       size_q;
   logic             unsigned_q;
   logic [CNT_W-1:0] retired_q;
   logic [DW-1:0]    load_data;
   logic             rd_is_zero;

   // The instruction sitting in WB retires whenever the stage is not held,
   // even if a flush is replacing it with a bubble this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         alu_q        <= '0;
         mem_data_q   <= '0;
         size_q       <= '0;
         unsigned_q   <= 1'b0;
         retired_q    <= '0;
      end else begin
         if (valid_q && !stall)
            retired_q <= retired_q + CNT_W'(1);
         if (flush) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            mem_data_q   <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
         end else if (!stall) begin
            valid_q      <= in_valid;
            mem_to_reg_q <= mem_to_reg_in;
            reg_write_q  <= reg_write_in;
            rd_q         <= rd_in;
            alu_q        <= alu_result_in;
            mem_data_q   <= mem_data_in;
            size_q       <= load_size_in;
            unsigned_q   <= load_unsigned_in;
         end
      end
   end

   load_align #(.DW(DW)) u_load_align (
      .word          (mem_data_q),
      .lo            (alu_q[ADDR_LO_W-1:0]),
      .size          (size_q),
      .load_unsigned (unsigned_q),
      .result        (load_data)
   );

   // rd and data still reach the outputs for register 0; only the enable drops.
   assign rd_is_zero    = (ZERO_REG != 0) && (rd_q == '0);
   assign wb_valid      = valid_q;
   assign wb_reg_write  = valid_q & reg_write_q & ~rd_is_zero;
   assign wb_rd         = rd_q;
   assign wb_data       = mem_to_reg_q ? load_data : alu_q;
   assign fwd_valid     = wb_reg_write;
   assign fwd_rd        = wb_rd;
   assign fwd_data      = wb_data;
   assign retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: directed vectors push expected
// write-back snapshots; a negedge monitor pops and compares them.
module tb_mem_wb_pipe_reg;
   import mem_wb_pkg::*;

   localparam logic [31:0] MEM_WORD = 32'h80FF_7F01;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, mem_to_reg_in, reg_write_in;
   logic [4:0]  rd_in;
   logic [31:0] alu_result_in, mem_data_in;
   logic [1:0]  load_size_in;
   logic        load_unsigned_in;
   logic        wb_valid, wb_reg_write, fwd_valid;
   logic [4:0]  wb_rd, fwd_rd;
   logic [31:0] wb_data, fwd_data;
   logic [2:0]  retired_count;

   typedef struct {
      int          id;
      logic        valid;
      logic        reg_write;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  count;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   vec_id = 0;

   logic        m_valid, m_rw;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [2:0]  m_cnt;

   mem_wb_pipe_reg #(.DW(32), .RA_W(5), .CNT_W(3), .ZERO_REG(1)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .in_valid         (in_valid),
      .mem_to_reg_in    (mem_to_reg_in),
      .reg_write_in     (reg_write_in),
      .rd_in            (rd_in),
      .alu_result_in    (alu_result_in),
      .mem_data_in      (mem_data_in),
      .load_size_in     (load_size_in),
      .load_unsigned_in (load_unsigned_in),
      .wb_valid         (wb_valid),
      .wb_reg_write     (wb_reg_write),
      .wb_rd            (wb_rd),
      .wb_data          (wb_data),
      .fwd_valid        (fwd_valid),
      .fwd_rd           (fwd_rd),
      .fwd_data         (fwd_data),
      .retired_count    (retired_count)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int id,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, id, act, exp);
      end
   endtask

   // exp_data is the hand-computed write-back value if this vector is captured.
   task automatic apply_stimulus(input logic r, input logic s, input logic f,
                                 input logic v, input logic m2r, input logic rw,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] exp_data);
      exp_t e;
      rst = r; stall = s; flush = f; in_valid = v;
      mem_to_reg_in = m2r; reg_write_in = rw; rd_in = rd;
      alu_result_in = alu; mem_data_in = mem;
      load_size_in = sz; load_unsigned_in = uns;
      if (r) begin
         m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0; m_cnt = '0;
      end else begin
         if (m_valid && !s) m_cnt = m_cnt + 3'd1;
         if (f) begin
            m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0;
         end else if (!s) begin
            m_valid = v; m_rw = rw; m_rd = rd; m_data = exp_data;
         end
      end
      vec_id++;
      e.id        = vec_id;
      e.valid     = m_valid;
      e.reg_write = m_valid & m_rw & (m_rd != 5'd0);
      e.rd        = m_rd;
      e.data      = m_data;
      e.count     = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rd, alu, 32'h0, LS_WORD, 1'b0, alu);
   endtask

   task automatic load_op(input logic [4:0] rd, input logic [31:0] alu,
                          input logic [1:0] sz, input logic uns, input logic [31:0] exp_data);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rd, alu, MEM_WORD, sz, uns, exp_data);
   endtask

   task automatic reset_op(input logic s, input logic f);
      apply_stimulus(1'b1, s, f, 1'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), 32'h0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_output("wb_valid", e.id, {31'b0, wb_valid}, {31'b0, e.valid});
         check_output("wb_reg_write", e.id, {31'b0, wb_reg_write}, {31'b0, e.reg_write});
         check_output("wb_rd", e.id, {27'b0, wb_rd}, {27'b0, e.rd});
         check_output("wb_data", e.id, wb_data, e.data);
         check_output("fwd_path", e.id, {fwd_data[25:0], fwd_rd, fwd_valid},
                      {e.data[25:0], e.rd, e.reg_write});
         check_output("retired_count", e.id, {29'b0, retired_count}, {29'b0, e.count});
      end
   end

   initial begin
      reset_op(1'($urandom), 1'($urandom));
      reset_op(1'($urandom), 1'($urandom));

      alu_op(5'd5, 32'h1234_5678);

      load_op(5'd1,  32'h0000_1001, LS_BYTE, 1'b0, 32'h0000_007F);
      load_op(5'd2,  32'h0000_1003, LS_BYTE, 1'b0, 32'hFFFF_FF80);
      load_op(5'd3,  32'h0000_1002, LS_HALF, 1'b1, 32'h0000_80FF);
      load_op(5'd4,  32'h0000_1002, LS_HALF, 1'b0, 32'hFFFF_80FF);
      load_op(5'd6,  32'h0000_1003, LS_HALF, 1'b0, 32'hFFFF_80FF);
      load_op(5'd8,  32'h0000_1002, LS_WORD, 1'b0, 32'h80FF_7F01);
      load_op(5'd9,  32'h0000_1001, 2'b11,   1'b1, 32'h80FF_7F01);
      load_op(5'd10, 32'h0000_1000, LS_BYTE, 1'b1, 32'h0000_0001);
      load_op(5'd11, 32'h0000_1002, LS_BYTE, 1'b1, 32'h0000_00FF);
      load_op(5'd12, 32'h0000_1003, LS_BYTE, 1'b1, 32'h0000_0080);

      // Stall holds a load in WB while the upstream inputs keep changing.
      load_op(5'd7, 32'h0000_2001, LS_BYTE, 1'b0, 32'h0000_007F);
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'(20 + i),
                        32'hDEAD_BEE0 + i, 32'h0, LS_WORD, 1'b0, 32'hDEAD_BEE0 + i);
      alu_op(5'd13, 32'hAAAA_5555);

      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd14, 32'h5, 32'h0, LS_WORD, 1'b0, 32'h5);
      alu_op(5'd15, 32'h0000_0077);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 32'h88, 32'h0, LS_WORD, 1'b0, 32'h88);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 32'h99, 32'h0, LS_WORD, 1'b0, 32'h99);

      alu_op(5'd0, 32'h0000_CAFE);
      reset_op(1'b1, 1'b1);

      // Nine retirements on a 3-bit counter wrap round to 1.
      for (int i = 0; i < 9; i++)
         alu_op(5'(i + 1), 32'h100 + i);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, LS_WORD, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, LS_WORD, 1'b0, 32'h0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
